gate_selftest: RTL and testbench

GATE_SELFTEST -- requirements
Module: gate_selftest

---
 rtl/gate_pkg.sv | 36 +++
 rtl/gate_ref_model.sv | 12 +
 rtl/gate_selftest.sv | 108 ++++++++++
 tb/tb_gate_selftest.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared definitions for the gate self-test: sweep FSM states, gate_res bit
// positions and the reference truth function for one operand pair.
package gate_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    DONE
  } state_e;

  localparam int unsigned GR_NOT_A = 0;
  localparam int unsigned GR_NOT_B = 1;
  localparam int unsigned GR_AND   = 2;
  localparam int unsigned GR_OR    = 3;
  localparam int unsigned GR_NOR   = 4;
  localparam int unsigned GR_NAND  = 5;
  localparam int unsigned GR_XOR   = 6;
  localparam int unsigned GR_XNOR  = 7;

  function automatic logic [7:0] gate_expected(input logic a, input logic b);
    logic [7:0] r;
    r           = '0;
    r[GR_NOT_A] = ~a;
    r[GR_NOT_B] = ~b;
    r[GR_AND]   = a & b;
    r[GR_OR]    = a | b;
    r[GR_NOR]   = ~(a | b);
    r[GR_NAND]  = ~(a & b);
    r[GR_XOR]   = a ^ b;
    r[GR_XNOR]  = ~(a ^ b);
    return r;
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model of the downstream gate stage for one vector.
module gate_ref_model
  import gate_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  output logic [7:0] exp_o
);

  assign exp_o = gate_expected(a_i, b_i);

endmodule

// File: rtl/gate_selftest.sv
// Truth-table self-test for an external gate stage: drives all four operand
// pairs, waits SETTLE_CYCLES, captures results and accumulates mismatches.
module gate_selftest
  import gate_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        a_out,
  output logic        b_out,
  input  logic [7:0]  gate_res,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_mask,
  output logic [31:0] res_log
);

  state_e      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  ab_q, ab_d;
  logic        pass_q, pass_d;
  logic [7:0]  err_q, err_d;
  logic [31:0] log_q, log_d;
  logic [7:0]  exp_w;

  gate_ref_model u_ref (
    .a_i   (ab_q[1]),
    .b_i   (ab_q[0]),
    .exp_o (exp_w)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      ab_q    <= '0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      log_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      ab_q    <= ab_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      log_q   <= log_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    ab_d    = ab_q;
    pass_d  = pass_q;
    err_d   = err_q;
    log_d   = log_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          k_d     = '0;
          pass_d  = 1'b0;
          err_d   = '0;
          log_d   = '0;
        end
      end
      DRIVE: begin
        ab_d    = k_q;
        cnt_d   = 4'(SETTLE_CYCLES);
        state_d = SETTLE;
      end
      SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = CHECK;
      end
      CHECK: begin
        log_d[{k_q, 3'b000} +: 8] = gate_res;
        err_d = err_q | (gate_res ^ exp_w);
        if (k_q == 2'd3) begin
          // pass is taken from the updated mask so it is valid during done
          pass_d  = (err_d == '0);
          state_d = DONE;
        end else begin
          k_d     = k_q + 2'd1;
          state_d = DRIVE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign a_out    = ab_q[1];
  assign b_out    = ab_q[0];
  assign busy     = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == CHECK);
  assign done     = (state_q == DONE);
  assign pass     = pass_q;
  assign err_mask = err_q;
  assign res_log  = log_q;

endmodule

// File: tb/tb_gate_selftest.sv
// Scoreboarded bench for gate_selftest with SETTLE_CYCLES of 1 and 3 and an
// in-loop gate stage whose AND output can be forced to 0.
module tb_gate_selftest;

  // slot3..slot0 for vectors 11,10,01,00 in xnor..not_a bit order
  localparam logic [31:0] CLEAN_LOG  = 32'h8C6A69B3;
  localparam logic [31:0] FAULTY_LOG = 32'h886A69B3;

  typedef struct {
    int unsigned start_edge;
    int unsigned lat;
    logic        pass;
    logic [7:0]  mask;
    logic [31:0] log;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned edges = 0;
  always @(posedge clk) edges <= edges + 1;

  int checks = 0;
  int fails  = 0;

  logic        rst1_n, start1, a1, b1, busy1, done1, pass1, fault1;
  logic [7:0]  res1, err1;
  logic [31:0] log1;
  logic        rst3_n, start3, a3, b3, busy3, done3, pass3;
  logic [7:0]  res3, err3;
  logic [31:0] log3;

  assign res1 = {~(a1 ^ b1), a1 ^ b1, ~(a1 & b1), ~(a1 | b1), a1 | b1,
                 (a1 & b1) & ~fault1, ~b1, ~a1};
  assign res3 = {~(a3 ^ b3), a3 ^ b3, ~(a3 & b3), ~(a3 | b3), a3 | b3,
                 a3 & b3, ~b3, ~a3};

  gate_selftest #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst1_n), .start(start1), .a_out(a1), .b_out(b1),
    .gate_res(res1), .busy(busy1), .done(done1), .pass(pass1),
    .err_mask(err1), .res_log(log1)
  );

  gate_selftest #(.SETTLE_CYCLES(3)) u3 (
    .clk(clk), .rst_n(rst3_n), .start(start3), .a_out(a3), .b_out(b3),
    .gate_res(res3), .busy(busy3), .done(done3), .pass(pass3),
    .err_mask(err3), .res_log(log3)
  );

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      if (q1.size() == 0) chk("u1 unexpected done", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        chk("u1 done latency", edges - e1.start_edge, e1.lat);
        chk("u1 pass", {31'd0, pass1}, {31'd0, e1.pass});
        chk("u1 err_mask", {24'd0, err1}, {24'd0, e1.mask});
        chk("u1 res_log", log1, e1.log);
        chk("u1 ab at done", {30'd0, a1, b1}, 32'd3);
        chk("u1 busy at done", {31'd0, busy1}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (done3 === 1'b1) begin
      if (q3.size() == 0) chk("u3 unexpected done", 32'd1, 32'd0);
      else begin
        e3 = q3.pop_front();
        chk("u3 done latency", edges - e3.start_edge, e3.lat);
        chk("u3 pass", {31'd0, pass3}, {31'd0, e3.pass});
        chk("u3 err_mask", {24'd0, err3}, {24'd0, e3.mask});
        chk("u3 res_log", log3, e3.log);
      end
    end
  end

  task automatic go1(input bit push, input logic p, input logic [7:0] m, input logic [31:0] l);
    @(negedge clk);
    start1 = 1'b1;
    if (push) q1.push_back('{edges + 1, 12, p, m, l});
    @(negedge clk);
    start1 = 1'b0;
    chk("u1 busy after start", {31'd0, busy1}, 32'd1);
  endtask

  task automatic drain1();
    for (int i = 0; i < 300 && q1.size() != 0; i++) @(negedge clk);
    chk("u1 sweep completion", q1.size(), 32'd0);
  endtask

  task automatic wait_done1();
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done1 === 1'b1) break;
    end
    chk("u1 done timeout", (i < 300) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst1_n = 1'b0; rst3_n = 1'b0;
    start1 = 1'b0; start3 = 1'b0; fault1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("u1 reset ctl", {27'd0, a1, b1, busy1, done1, pass1}, 32'd0);
    chk("u1 reset err_mask", {24'd0, err1}, 32'd0);
    chk("u1 reset res_log", log1, 32'd0);
    chk("u3 reset state", {a3, b3, busy3, done3, pass3, err3, log3[18:0]}, 32'd0);
    // start held during reset must not launch a sweep
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("u1 reset beats start", {31'd0, busy1}, 32'd0);
    rst1_n = 1'b1; rst3_n = 1'b1;
    @(negedge clk);

    go1(1'b1, 1'b1, 8'h00, CLEAN_LOG);
    drain1();
    repeat (5) @(negedge clk);
    chk("u1 idle res_log hold", log1, CLEAN_LOG);
    chk("u1 idle pass hold", {31'd0, pass1}, 32'd1);
    chk("u1 idle ab hold", {30'd0, a1, b1}, 32'd3);

    fault1 = 1'b1;
    go1(1'b1, 1'b0, 8'h04, FAULTY_LOG);
    wait_done1();
    fault1 = 1'b0;
    go1(1'b1, 1'b1, 8'h00, CLEAN_LOG);
    chk("u1 b2b err_mask cleared", {24'd0, err1}, 32'd0);
    chk("u1 b2b res_log cleared", log1, 32'd0);
    chk("u1 b2b pass cleared", {31'd0, pass1}, 32'd0);
    drain1();

    // abort during SETTLE of vector 2
    go1(1'b0, 1'b0, 8'h00, 32'd0);
    repeat (7) @(negedge clk);
    chk("u1 vector 2 driven", {30'd0, a1, b1}, 32'd2);
    rst1_n = 1'b0;
    @(negedge clk);
    chk("u1 abort ctl", {27'd0, a1, b1, busy1, done1, pass1}, 32'd0);
    chk("u1 abort err_mask", {24'd0, err1}, 32'd0);
    chk("u1 abort res_log", log1, 32'd0);
    rst1_n = 1'b1;
    repeat (20) @(negedge clk);
    go1(1'b1, 1'b1, 8'h00, CLEAN_LOG);
    drain1();

    @(negedge clk);
    start3 = 1'b1;
    q3.push_back('{edges + 1, 20, 1'b1, 8'h00, CLEAN_LOG});
    @(negedge clk);
    start3 = 1'b0;
    for (int p = 0; p < 3; p++) begin
      repeat (5) @(negedge clk);
      start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
    end
    for (int i = 0; i < 300 && q3.size() != 0; i++) @(negedge clk);
    chk("u3 sweep completion", q3.size(), 32'd0);
    repeat (30) @(negedge clk);
    chk("u3 idle after sweep", {31'd0, busy3}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
